// File: rtl/cnn_tile_ctrl.sv
// CNN layer sequencer: walks col, input-channel tile, row, output tile and
// paces each row through sync phases gated on filter/IFM buffer readiness.
module cnn_tile_ctrl #(
  parameter int W_SIZE       = 10,
  parameter int W_CHANNEL    = 8,
  parameter int W_OTILE      = 6,
  parameter int W_FRAME_SIZE = 24,
  parameter int W_DELAY      = 12,
  parameter int N_PESYNC     = 2,
  parameter int IFM_BUF_CNT  = 4,
  parameter int W_IFM_BUF    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel,
  input  logic [W_OTILE-1:0]      q_otiles,
  input  logic [IFM_BUF_CNT-1:0]  q_ifm_buf_done,
  input  logic                    q_filter_buf_done,
  input  logic                    i_stall,
  output logic                    o_busy,
  output logic                    o_cfg_err,
  output logic                    o_vsync_run,
  output logic                    o_hsync_run,
  output logic                    o_pesync_run,
  output logic                    o_data_run,
  output logic [W_DELAY-1:0]      o_sync_cnt,
  output logic                    o_fire,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_OTILE-1:0]      o_otile,
  output logic                    o_is_first_row,
  output logic                    o_is_last_row,
  output logic                    o_is_first_col,
  output logic                    o_is_last_col,
  output logic                    o_is_last_chn,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_tile,
  output logic                    o_end_frame
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_HSYNC  = 3'd2;
  localparam logic [2:0] S_PESYNC = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;

  localparam bit               HAS_PESYNC  = (N_PESYNC != 0);
  localparam logic [W_DELAY-1:0] PESYNC_LAST = W_DELAY'((N_PESYNC > 0) ? N_PESYNC - 1 : 0);

  logic [2:0]              state_q, state_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_CHANNEL-1:0]    chn_q, chn_d;
  logic [W_OTILE-1:0]      otile_q, otile_d;
  logic [W_FRAME_SIZE-1:0] data_count_q, data_count_d;
  logic [W_DELAY-1:0]      sync_cnt_q, sync_cnt_d;

  logic                    busy;
  logic                    cfg_ok;
  logic                    first_row, last_row, first_col, last_col, last_chn, last_otile;
  logic [W_IFM_BUF-1:0]    ifm_idx;
  logic                    rows_ok;
  logic                    fire;
  logic                    beat_last_row;
  logic                    in_sync;

  always_comb begin
    busy       = (state_q != S_IDLE);
    cfg_ok     = (|q_width) & (|q_height) & (|q_channel) & (|q_otiles);
    first_row  = (row_q == '0);
    last_row   = (row_q == q_height - W_SIZE'(1));
    first_col  = (col_q == '0);
    last_col   = (col_q == q_width - W_SIZE'(1));
    last_chn   = (chn_q == q_channel - W_CHANNEL'(1));
    last_otile = (otile_q == q_otiles - W_OTILE'(1));
    // Next row's ring slot must be filled unless this is the last row; the
    // first row additionally needs slot 0.
    ifm_idx    = row_q[W_IFM_BUF-1:0] + W_IFM_BUF'(1);
    rows_ok    = (last_row | q_ifm_buf_done[ifm_idx]) & (~first_row | q_ifm_buf_done[0]);
    fire       = (state_q == S_DATA) & ~i_stall;
    beat_last_row = last_col & last_chn & last_row;
    in_sync    = (state_q == S_VSYNC) | (state_q == S_HSYNC) | (state_q == S_PESYNC);
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    chn_d        = chn_q;
    otile_d      = otile_q;
    data_count_d = data_count_q;
    case (state_q)
      S_IDLE: begin
        if (q_start && cfg_ok) begin
          state_d      = S_VSYNC;
          row_d        = '0;
          col_d        = '0;
          chn_d        = '0;
          otile_d      = '0;
          data_count_d = '0;
        end
      end
      S_VSYNC: begin
        if (q_filter_buf_done) state_d = S_HSYNC;
      end
      S_HSYNC: begin
        if (rows_ok) state_d = HAS_PESYNC ? S_PESYNC : S_DATA;
      end
      S_PESYNC: begin
        if (sync_cnt_q == PESYNC_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (fire) begin
          data_count_d = data_count_q + W_FRAME_SIZE'(1);
          if (!last_col) begin
            col_d = col_q + W_SIZE'(1);
          end else begin
            col_d = '0;
            if (!last_chn) begin
              chn_d = chn_q + W_CHANNEL'(1);
            end else begin
              chn_d = '0;
              if (!last_row) begin
                row_d   = row_q + W_SIZE'(1);
                state_d = S_HSYNC;
              end else begin
                row_d = '0;
                if (!last_otile) begin
                  otile_d = otile_q + W_OTILE'(1);
                  state_d = S_VSYNC;
                end else begin
                  otile_d = '0;
                  state_d = S_IDLE;
                end
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Phase timer restarts on any state change and saturates rather than wraps.
    if (!in_sync || (state_d != state_q)) begin
      sync_cnt_d = '0;
    end else if (&sync_cnt_q) begin
      sync_cnt_d = sync_cnt_q;
    end else begin
      sync_cnt_d = sync_cnt_q + W_DELAY'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      chn_q        <= '0;
      otile_q      <= '0;
      data_count_q <= '0;
      sync_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      chn_q        <= chn_d;
      otile_q      <= otile_d;
      data_count_q <= data_count_d;
      sync_cnt_q   <= sync_cnt_d;
    end
  end

  // Position flags are qualified by busy so an idle block drives all zeros.
  always_comb begin
    o_busy         = busy;
    o_cfg_err      = (state_q == S_IDLE) & q_start & ~cfg_ok;
    o_vsync_run    = (state_q == S_VSYNC);
    o_hsync_run    = (state_q == S_HSYNC);
    o_pesync_run   = (state_q == S_PESYNC);
    o_data_run     = (state_q == S_DATA);
    o_sync_cnt     = sync_cnt_q;
    o_fire         = fire;
    o_row          = row_q;
    o_col          = col_q;
    o_chn          = chn_q;
    o_otile        = otile_q;
    o_is_first_row = busy & first_row;
    o_is_last_row  = busy & last_row;
    o_is_first_col = busy & first_col;
    o_is_last_col  = busy & last_col;
    o_is_last_chn  = busy & last_chn;
    o_data_count   = data_count_q;
    o_end_tile     = fire & beat_last_row & ~last_otile;
    o_end_frame    = fire & beat_last_row & last_otile;
  end

endmodule

// File: tb/tb_cnn_tile_ctrl.sv
// Scoreboard bench for cnn_tile_ctrl: expected beats come from nested loops
// over the frame; a negedge monitor pops and compares on every fire.
module tb_cnn_tile_ctrl;
  localparam int N_PESYNC    = 2;
  localparam int IFM_BUF_CNT = 4;

  typedef logic [79:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_start = 1'b0;
  logic [9:0]  q_width = 10'd4;
  logic [9:0]  q_height = 10'd3;
  logic [7:0]  q_channel = 8'd2;
  logic [5:0]  q_otiles = 6'd1;
  logic [3:0]  q_ifm_buf_done = 4'hF;
  logic        q_filter_buf_done = 1'b1;
  logic        i_stall = 1'b0;

  logic        o_busy, o_cfg_err, o_vsync_run, o_hsync_run, o_pesync_run, o_data_run;
  logic [11:0] o_sync_cnt;
  logic        o_fire;
  logic [9:0]  o_row, o_col;
  logic [7:0]  o_chn;
  logic [5:0]  o_otile;
  logic        o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col, o_is_last_chn;
  logic [23:0] o_data_count;
  logic        o_end_tile, o_end_frame;

  cnn_tile_ctrl #(.N_PESYNC(N_PESYNC), .IFM_BUF_CNT(IFM_BUF_CNT)) dut (
    .clk(clk), .rst(rst), .q_start(q_start), .q_width(q_width), .q_height(q_height),
    .q_channel(q_channel), .q_otiles(q_otiles), .q_ifm_buf_done(q_ifm_buf_done),
    .q_filter_buf_done(q_filter_buf_done), .i_stall(i_stall), .o_busy(o_busy),
    .o_cfg_err(o_cfg_err), .o_vsync_run(o_vsync_run), .o_hsync_run(o_hsync_run),
    .o_pesync_run(o_pesync_run), .o_data_run(o_data_run), .o_sync_cnt(o_sync_cnt),
    .o_fire(o_fire), .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_otile(o_otile),
    .o_is_first_row(o_is_first_row), .o_is_last_row(o_is_last_row),
    .o_is_first_col(o_is_first_col), .o_is_last_col(o_is_last_col),
    .o_is_last_chn(o_is_last_chn), .o_data_count(o_data_count),
    .o_end_tile(o_end_tile), .o_end_frame(o_end_frame)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int r, input int c, input int k, input int t, input int n,
                               input bit fr, input bit lr, input bit fc, input bit lc,
                               input bit lk, input bit et, input bit ef);
    return {10'(r), 10'(c), 8'(k), 6'(t), 24'(n), fr, lr, fc, lc, lk, et, ef};
  endfunction

  function automatic beat_t pack_dut();
    return {o_row, o_col, o_chn, o_otile, o_data_count, o_is_first_row, o_is_last_row,
            o_is_first_col, o_is_last_col, o_is_last_chn, o_end_tile, o_end_frame};
  endfunction

  function automatic logic [127:0] outvec();
    return {o_busy, o_cfg_err, o_vsync_run, o_hsync_run, o_pesync_run, o_data_run,
            o_sync_cnt, o_fire, pack_dut()};
  endfunction

  function automatic bit rows_ok_tb();
    int r = int'(o_row);
    bit last = (r == int'(q_height) - 1);
    bit first = (r == 0);
    int idx = (r + 1) % IFM_BUF_CNT;
    return (last || q_ifm_buf_done[idx]) && (!first || q_ifm_buf_done[0]);
  endfunction

  // Monitor: phase sequencing, phase timer, fire qualification, beat scoreboard.
  int    cycle = 0;
  bit    prev_valid = 0;
  int    prev_phase = 0;
  int    model_cnt = 0;
  int    pes_run = 0;
  bit    prev_filter, prev_rows_ok, prev_start_ok, prev_fire;
  beat_t prev_beat;
  int    hs_entries = 0;
  int    fires_total = 0;
  int    start_cyc = 0;
  int    first_lat = 0;
  bit    got_first = 0;

  always @(negedge clk) begin
    int    phase;
    int    runs;
    int    exp_phase;
    beat_t act;
    beat_t exp;
    cycle++;
    if (rst) begin
      prev_valid = 0;
    end else begin
      runs = int'(o_vsync_run) + int'(o_hsync_run) + int'(o_pesync_run) + int'(o_data_run);
      phase = o_vsync_run ? 1 : o_hsync_run ? 2 : o_pesync_run ? 3 : o_data_run ? 4 : 0;
      check("run_onehot", 128'(runs <= 1), 128'(1));
      check("busy", 128'(o_busy), 128'(phase != 0));
      if (prev_valid) begin
        exp_phase = prev_phase;
        case (prev_phase)
          0: exp_phase = prev_start_ok ? 1 : 0;
          1: exp_phase = prev_filter ? 2 : 1;
          2: exp_phase = prev_rows_ok ? ((N_PESYNC > 0) ? 3 : 4) : 2;
          3: exp_phase = (pes_run == N_PESYNC) ? 4 : 3;
          default: begin
            if (!prev_fire) exp_phase = 4;
            else if (!(prev_beat[3] && prev_beat[2])) exp_phase = 4;
            else if (!prev_beat[5]) exp_phase = 2;
            else exp_phase = prev_beat[1] ? 1 : 0;
          end
        endcase
        check("next_phase", 128'(phase), 128'(exp_phase));
      end
      if (prev_valid && phase == prev_phase) model_cnt = (model_cnt == 4095) ? 4095 : model_cnt + 1;
      else model_cnt = 0;
      if (phase >= 1 && phase <= 3) check("sync_cnt", 128'(o_sync_cnt), 128'(model_cnt));
      pes_run = (phase == 3) ? ((prev_valid && prev_phase == 3) ? pes_run + 1 : 1) : 0;
      if (phase == 2 && !(prev_valid && prev_phase == 2)) hs_entries++;
      check("fire", 128'(o_fire), 128'(phase == 4 && !i_stall));
      prev_fire = o_fire;
      if (o_fire) begin
        fires_total++;
        if (!got_first) begin
          first_lat = cycle - start_cyc;
          got_first = 1;
        end
        act = pack_dut();
        if (sb.size() == 0) begin
          check("unexpected_beat", 128'(act), 128'(0));
          prev_beat = act;
        end else begin
          exp = sb.pop_front();
          check("beat", 128'(act), 128'(exp));
          prev_beat = exp;
        end
      end
      prev_start_ok = q_start && (q_width != 0) && (q_height != 0) && (q_channel != 0) && (q_otiles != 0);
      if (phase == 0 && prev_start_ok) begin
        start_cyc = cycle;
        got_first = 0;
      end
      prev_filter  = q_filter_buf_done;
      prev_rows_ok = rows_ok_tb();
      prev_phase   = phase;
      prev_valid   = 1;
    end
  end

  // stall_mode: 0 none, 1 toggle, 2 random. gap_mode: 1 filter gap per tile, 2 random.
  // ifm_mode: 1 row-4 buffer hold, 2 random. rst_mode: reset at row 1.
  task automatic run_frame(input int w, input int h, input int c, input int ot,
                           input int stall_mode, input int gap_mode, input int ifm_mode,
                           input bit rst_mode, input bit chk_lat);
    int n = 0;
    int cyc = 0;
    int gap = 0;
    int vs_cycles = 0;
    int hs4 = 0;
    int hs5 = 0;
    bit did_rst = 0;
    int total = w * h * c * ot;
    q_width = 10'(w); q_height = 10'(h); q_channel = 8'(c); q_otiles = 6'(ot);
    for (int t = 0; t < ot; t++)
      for (int y = 0; y < h; y++)
        for (int k = 0; k < c; k++)
          for (int x = 0; x < w; x++) begin
            bit la = (x == w - 1) && (k == c - 1) && (y == h - 1);
            sb.push_back(mk(y, x, k, t, n, y == 0, y == h - 1, x == 0, x == w - 1,
                            k == c - 1, la && (t != ot - 1), la && (t == ot - 1)));
            n++;
          end
    hs_entries = 0;
    fires_total = 0;
    q_start = 1'b1;
    @(posedge clk); #1;
    q_start = 1'b0;
    while (o_busy && cyc < 5000 && !did_rst) begin
      if (rst_mode && o_data_run && o_row == 10'd1) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outputs", outvec(), 128'(0));
        sb.delete();
        did_rst = 1;
      end else begin
        if (o_vsync_run) vs_cycles++;
        if (gap_mode == 1) begin
          if (o_end_tile) begin
            q_filter_buf_done = 1'b0;
            gap = 0;
          end else if (o_vsync_run && !q_filter_buf_done) begin
            gap++;
            if (gap == 5) q_filter_buf_done = 1'b1;
          end
        end else if (gap_mode == 2) begin
          q_filter_buf_done = ($urandom_range(0, 2) != 0);
        end
        if (ifm_mode == 1) begin
          if (o_data_run && o_row == 10'd3) q_ifm_buf_done[1] = 1'b0;
          if (o_data_run && o_row == 10'd4) q_ifm_buf_done[2] = 1'b0;
          if (o_hsync_run && o_row == 10'd4) begin
            hs4++;
            if (hs4 == 10) q_ifm_buf_done[1] = 1'b1;
          end
          if (o_hsync_run && o_row == 10'd5) hs5++;
        end else if (ifm_mode == 2) begin
          q_ifm_buf_done = ~(4'($urandom) & 4'($urandom));
        end
        if (stall_mode == 1) i_stall = ~i_stall;
        else if (stall_mode == 2) i_stall = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!did_rst) begin
      check("frame_timeout", 128'(cyc < 5000), 128'(1));
      check("end_busy", 128'(o_busy), 128'(0));
      check("end_data_count", 128'(o_data_count), 128'(total % (1 << 24)));
      check("fire_total", 128'(fires_total), 128'(total));
      check("sb_drained", 128'(sb.size()), 128'(0));
      check("hsync_entries", 128'(hs_entries), 128'(h * ot));
      if (chk_lat) check("first_fire_latency", 128'(first_lat), 128'(3 + N_PESYNC));
      if (gap_mode == 1) check("vsync_cycles", 128'(vs_cycles), 128'(1 + 5 * (ot - 1)));
      if (ifm_mode == 1) begin
        check("hsync_row4_hold", 128'(hs4), 128'(10));
        check("hsync_last_row", 128'(hs5), 128'(1));
      end
    end
    $display("frame w=%0d h=%0d c=%0d ot=%0d stall=%0d gap=%0d ifm=%0d rst=%0d fires=%0d cycles=%0d",
             w, h, c, ot, stall_mode, gap_mode, ifm_mode, rst_mode, fires_total, cyc);
    i_stall = 1'b0;
    q_filter_buf_done = 1'b1;
    q_ifm_buf_done = 4'hF;
    @(posedge clk); #1;
  endtask

  task automatic cfg_err_case(input int w, input int h, input int c, input int ot);
    q_width = 10'(w); q_height = 10'(h); q_channel = 8'(c); q_otiles = 6'(ot);
    q_start = 1'b1;
    #1;
    check("cfg_err_pulse", 128'(o_cfg_err), 128'(1));
    @(posedge clk); #1;
    q_start = 1'b0;
    #1;
    check("cfg_err_busy", 128'(o_busy), 128'(0));
    check("cfg_err_clear", 128'(o_cfg_err), 128'(0));
    $display("cfg_err w=%0d h=%0d c=%0d ot=%0d busy=%0d", w, h, c, ot, o_busy);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", outvec(), 128'(0));
    run_frame(4, 3, 2, 1, 0, 0, 0, 0, 1);
    run_frame(4, 3, 2, 3, 0, 1, 0, 0, 0);
    run_frame(4, 6, 2, 1, 0, 0, 1, 0, 0);
    run_frame(4, 3, 2, 1, 1, 0, 0, 0, 0);
    cfg_err_case(4, 3, 0, 1);
    cfg_err_case(0, 3, 2, 1);
    cfg_err_case(4, 3, 2, 0);
    run_frame(4, 3, 2, 1, 0, 0, 0, 1, 0);
    run_frame(4, 3, 2, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(1, 3),
                $urandom_range(1, 3), 2, 2, 2, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
